everloop_stream: RTL

//  Parametrised Everloop ring driver, successor to the fixed everloop serialiser.
//  - Reads N_LEDS*BPL bytes from a synchronous frame RAM port (1-cycle latency).
//  - Applies global brightness scaling to each byte.
//  - Emits the single-wire WS2812/SK6812 waveform on led_ctl.
//  - Supports single-shot and continuous-refresh modes, with a start/busy/done handshake.

---
 rtl/everloop_pkg.sv | 37 +++
 rtl/everloop_bitgen.sv | 50 +++++
 rtl/everloop_stream.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/everloop_pkg.sv
// Shared definitions for the Everloop ring driver: state encoding, default
// 50MHz timing, counter-width helper and the brightness scaler.
package everloop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

  localparam int DEF_N_LEDS  = 18;
  localparam int DEF_BPL     = 4;
  localparam int DEF_ADR_W   = 11;
  localparam int DEF_T_BIT   = 63;
  localparam int DEF_T0H     = 18;
  localparam int DEF_T1H     = 35;
  localparam int DEF_T_LATCH = 4000;

  // Bits needed to hold values 0..n-1 (minimum 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // bright=255 is unity gain; bright=0 maps every byte to 0.
  function automatic logic [7:0] scale_byte(input logic [7:0] d, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, d} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

endpackage

// File: rtl/everloop_bitgen.sv
// One-bit WS2812 waveform generator: high for T0H/T1H cycles, low for the
// remainder of T_BIT. bit_done flags the final cycle so the next load is gapless.
module everloop_bitgen
  import everloop_pkg::*;
#(
  parameter int T_BIT = DEF_T_BIT,
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic bit_val,
  output logic line,
  output logic bit_done
);

  localparam int CW = clog2(T_BIT + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_hi;
  logic          r_active;
  logic          r_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_active <= 1'b0;
      r_line   <= 1'b0;
    end else if (load) begin
      r_cnt    <= '0;
      r_hi     <= bit_val ? CW'(T1H) : CW'(T0H);
      r_active <= 1'b1;
      r_line   <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == CW'(T_BIT - 1)) begin
        r_active <= 1'b0;
        r_line   <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_line <= ((r_cnt + 1'b1) < r_hi);
      end
    end
  end

  assign line     = r_line;
  assign bit_done = r_active && (r_cnt == CW'(T_BIT - 1));

endmodule

// File: rtl/everloop_stream.sv
// Everloop ring driver: fetches N_LEDS*BPL bytes from frame RAM, scales them by
// the global brightness and serialises them MSB first onto led_ctl.
// Handshake: start is sampled only while busy=0; busy rises on the accepting edge
// and falls on the same edge that raises the 1-cycle frame_done pulse (cont=0).
module everloop_stream
  import everloop_pkg::*;
#(
  parameter int N_LEDS  = DEF_N_LEDS,
  parameter int BPL     = DEF_BPL,
  parameter int ADR_W   = DEF_ADR_W,
  parameter int T_BIT   = DEF_T_BIT,
  parameter int T0H     = DEF_T0H,
  parameter int T1H     = DEF_T1H,
  parameter int T_LATCH = DEF_T_LATCH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [7:0]       bright,
  output logic [ADR_W-1:0] adr,
  output logic             rd_en,
  input  logic [7:0]       dat,
  output logic             led_ctl,
  output logic             busy,
  output logic             frame_done,
  output logic [1:0]       o_dbg_state
);

  localparam int TOTAL = N_LEDS * BPL;
  localparam int BCW   = clog2(TOTAL + 1);
  localparam int LCW   = clog2(T_LATCH + 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_pf_phase;
  logic [ADR_W-1:0] r_adr;
  logic             r_rd_en;
  logic             r_dat_vld;
  logic [7:0]       r_bright;
  logic [6:0]       r_rem;
  logic [7:0]       r_next;
  logic [2:0]       r_bit_idx;
  logic [BCW-1:0]   r_byte_idx;
  logic [LCW-1:0]   r_lat_cnt;
  logic             r_busy;
  logic             r_frame_done;

  logic       w_bit_done;
  logic       w_line;
  logic       w_bg_load;
  logic       w_bg_val;
  logic [7:0] w_scaled;
  logic       w_last_byte;
  logic       w_lat_end;

  assign w_scaled    = scale_byte(dat, r_bright);
  assign w_last_byte = (r_byte_idx == BCW'(TOTAL - 1));
  assign w_lat_end   = (r_lat_cnt == LCW'(T_LATCH - 1));

  everloop_bitgen #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bitgen (
    .clk      (clk),
    .rst      (rst),
    .load     (w_bg_load),
    .bit_val  (w_bg_val),
    .line     (w_line),
    .bit_done (w_bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_bg_load = 1'b0;
    w_bg_val  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        if (r_pf_phase) begin
          w_next    = ST_SHIFT;
          w_bg_load = 1'b1;
          w_bg_val  = w_scaled[7];
        end
      end
      ST_SHIFT: begin
        if (w_bit_done) begin
          if (r_bit_idx != 3'd7) begin
            w_bg_load = 1'b1;
            w_bg_val  = r_rem[6];
          end else if (!w_last_byte) begin
            w_bg_load = 1'b1;
            w_bg_val  = r_next[7];
          end else begin
            w_next = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (w_lat_end) w_next = cont ? ST_PREFETCH : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pf_phase   <= 1'b0;
      r_adr        <= '0;
      r_rd_en      <= 1'b0;
      r_dat_vld    <= 1'b0;
      r_bright     <= '0;
      r_rem        <= '0;
      r_next       <= '0;
      r_bit_idx    <= '0;
      r_byte_idx   <= '0;
      r_lat_cnt    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_dat_vld    <= r_rd_en;
      if (r_dat_vld) r_next <= w_scaled;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_adr    <= base_adr;
            r_bright <= bright;
            r_rd_en  <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        ST_PREFETCH: begin
          r_pf_phase <= ~r_pf_phase;
          if (r_pf_phase) begin
            r_rem      <= w_scaled[6:0];
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_bit_done) begin
            if (r_bit_idx != 3'd7) begin
              r_rem     <= {r_rem[5:0], 1'b0};
              r_bit_idx <= r_bit_idx + 3'd1;
              // Fetch the following byte early so it is ready well before bit 7 ends.
              if (r_bit_idx == 3'd0 && !w_last_byte) begin
                r_adr   <= r_adr + 1'b1;
                r_rd_en <= 1'b1;
              end
            end else if (!w_last_byte) begin
              r_rem      <= r_next[6:0];
              r_bit_idx  <= '0;
              r_byte_idx <= r_byte_idx + 1'b1;
            end else begin
              r_lat_cnt <= '0;
            end
          end
        end
        ST_LATCH: begin
          if (w_lat_end) begin
            r_frame_done <= 1'b1;
            if (cont) begin
              r_adr    <= base_adr;
              r_bright <= bright;
              r_rd_en  <= 1'b1;
            end else begin
              r_busy <= 1'b0;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign adr         = r_adr;
  assign rd_en       = r_rd_en;
  assign led_ctl     = w_line;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign o_dbg_state = r_state;

endmodule
